// File: rtl/vx_dispatch_lane_serializer_if.sv
// vx_dispatch_lane_serializer_if: dispatch packet input bundle and lane-batch beat output bundle
interface vx_dispatch_lane_serializer_if #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_W       = 64
);
  localparam int BATCHES = NUM_THREADS / NUM_LANES;
  localparam int PID_W   = BATCHES > 1 ? $clog2(BATCHES) : 1;
  logic                        in_valid;
  logic                        in_ready;
  logic [HDR_W-1:0]            in_hdr;
  logic [NUM_THREADS-1:0]      in_tmask;
  logic [NUM_THREADS*XLEN-1:0] in_rs1, in_rs2, in_rs3;
  logic                        out_valid;
  logic                        out_ready;
  logic [HDR_W-1:0]            out_hdr;
  logic [NUM_LANES-1:0]        out_tmask;
  logic [NUM_LANES*XLEN-1:0]   out_rs1, out_rs2, out_rs3;
  logic [PID_W-1:0]            out_pid;
  logic                        out_sop;
  logic                        out_eop;
  modport slave (
    input  in_valid, in_hdr, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
    output in_ready, out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3, out_pid, out_sop, out_eop
  );
  modport master (
    output in_valid, in_hdr, in_tmask, in_rs1, in_rs2, in_rs3, out_ready,
    input  in_ready, out_valid, out_hdr, out_tmask, out_rs1, out_rs2, out_rs3, out_pid, out_sop, out_eop
  );
endinterface

// File: rtl/vx_dispatch_lane_serializer.sv
// vx_dispatch_lane_serializer: buffers one dispatch packet and replays its non-empty lane batches as tagged beats
module vx_dispatch_lane_serializer #(
  parameter int NUM_THREADS = 4,
  parameter int NUM_LANES   = 2,
  parameter int XLEN        = 32,
  parameter int HDR_W       = 64
) (
  input logic clk,
  input logic reset_n,
  vx_dispatch_lane_serializer_if.slave bus
);
  localparam int BATCHES = NUM_THREADS / NUM_LANES;
  localparam int PID_W   = BATCHES > 1 ? $clog2(BATCHES) : 1;
  typedef enum logic {IDLE, SEND} state_t;
  state_t                      r_state, w_next;
  logic [HDR_W-1:0]            r_hdr;
  logic [NUM_THREADS-1:0]      r_tmask;
  logic [NUM_THREADS*XLEN-1:0] r_rs1, r_rs2, r_rs3;
  logic [PID_W-1:0]            r_pid, w_first, w_above;
  logic                        r_sop, w_has_above, w_fire, w_eop, w_acc;
  // An all-zero mask falls back to batch 0 so the packet still produces one beat.
  always_comb begin
    w_first     = '0;
    w_above     = r_pid;
    w_has_above = 1'b0;
    for (int b = BATCHES - 1; b >= 0; b--) begin
      if (|bus.in_tmask[b*NUM_LANES +: NUM_LANES]) w_first = PID_W'(b);
      if (b > int'(r_pid) && |r_tmask[b*NUM_LANES +: NUM_LANES]) begin
        w_above     = PID_W'(b);
        w_has_above = 1'b1;
      end
    end
  end
  assign bus.out_valid = r_state == SEND;
  assign w_eop         = bus.out_valid & ~w_has_above;
  assign w_fire        = bus.out_valid & bus.out_ready;
  assign bus.in_ready  = (r_state == IDLE) | (w_fire & w_eop);
  assign w_acc         = bus.in_valid & bus.in_ready;
  always_comb begin
    w_next = r_state;
    w_next = w_acc ? SEND : (w_fire & w_eop) ? IDLE : r_state;
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_pid   <= '0;
      r_sop   <= 1'b0;
    end else begin
      r_state <= w_next;
      if (w_acc) begin
        r_pid <= w_first;
        r_sop <= 1'b1;
      end else if (w_fire & ~w_eop) begin
        r_pid <= w_above;
        r_sop <= 1'b0;
      end
    end
  end
  always_ff @(posedge clk) begin
    if (w_acc) begin
      r_hdr   <= bus.in_hdr;
      r_tmask <= bus.in_tmask;
      r_rs1   <= bus.in_rs1;
      r_rs2   <= bus.in_rs2;
      r_rs3   <= bus.in_rs3;
    end
  end
  assign bus.out_hdr   = r_hdr;
  assign bus.out_tmask = r_tmask[int'(r_pid)*NUM_LANES +: NUM_LANES];
  assign bus.out_rs1   = r_rs1[int'(r_pid)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign bus.out_rs2   = r_rs2[int'(r_pid)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign bus.out_rs3   = r_rs3[int'(r_pid)*NUM_LANES*XLEN +: NUM_LANES*XLEN];
  assign bus.out_pid   = r_pid;
  assign bus.out_sop   = bus.out_valid & r_sop;
  assign bus.out_eop   = w_eop;
  a_first_beat: assert property (@(posedge clk) disable iff (!reset_n)
    w_acc |=> bus.out_valid && bus.out_sop);
  a_pid_rises: assert property (@(posedge clk) disable iff (!reset_n)
    w_fire && !w_eop |=> bus.out_valid && !bus.out_sop && bus.out_pid > $past(bus.out_pid));
  a_stall_hold: assert property (@(posedge clk) disable iff (!reset_n)
    bus.out_valid && !bus.out_ready |=> bus.out_valid && $stable(bus.out_pid) && $stable(bus.out_hdr) && $stable(bus.out_sop));
endmodule

// File: tb/tb_vx_dispatch_lane_serializer.sv
// tb_vx_dispatch_lane_serializer: directed checks of beat order, skipping, stalls, back-to-back and reset
module tb_vx_dispatch_lane_serializer;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_bad = 0;
  localparam logic [63:0]  H1 = 64'h1111_0000_0000_0001, H2 = 64'h2222_0000_0000_0002;
  localparam logic [63:0]  H3 = 64'h3333_0000_0000_0003, H4 = 64'h4444_0000_0000_0004;
  localparam logic [63:0]  H5 = 64'h5555_0000_0000_0005, H6 = 64'h6666_0000_0000_0006;
  localparam logic [63:0]  H7 = 64'h7777_0000_0000_0007, H8 = 64'h8888_0000_0000_0008;
  localparam logic [63:0]  LO1 = 64'h1000_0001_1000_0000, HI1 = 64'h1000_0003_1000_0002;
  localparam logic [63:0]  HI2 = 64'h2000_0003_2000_0002, HI3 = 64'h3000_0003_3000_0002;
  always #5 clk = ~clk;
  vx_dispatch_lane_serializer_if #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .HDR_W(64)) bus ();
  vx_dispatch_lane_serializer #(.NUM_THREADS(4), .NUM_LANES(2), .XLEN(32), .HDR_W(64)) dut (
    .clk(clk), .reset_n(reset_n), .bus(bus.slave)
  );
  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    n_cmp++;
    assert (got === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  task automatic beat(input string tag, input logic [0:0] pid, input logic sop, input logic eop,
                      input logic [1:0] tm, input logic [63:0] hdr);
    chk({tag, ".valid"}, 128'(bus.out_valid), 128'(1'b1));
    chk({tag, ".pid"},   128'(bus.out_pid), 128'(pid));
    chk({tag, ".sop"},   128'(bus.out_sop), 128'(sop));
    chk({tag, ".eop"},   128'(bus.out_eop), 128'(eop));
    chk({tag, ".tmask"}, 128'(bus.out_tmask), 128'(tm));
    chk({tag, ".hdr"},   128'(bus.out_hdr), 128'(hdr));
  endtask
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  initial begin
    bus.in_valid = 1'b0; bus.out_ready = 1'b1; bus.in_hdr = '0; bus.in_tmask = '0;
    bus.in_rs1 = {32'h1000_0003, 32'h1000_0002, 32'h1000_0001, 32'h1000_0000};
    bus.in_rs2 = {32'h2000_0003, 32'h2000_0002, 32'h2000_0001, 32'h2000_0000};
    bus.in_rs3 = {32'h3000_0003, 32'h3000_0002, 32'h3000_0001, 32'h3000_0000};
    @(negedge clk);
    chk("rst.valid", 128'(bus.out_valid), 128'(1'b0));
    chk("rst.pid", 128'(bus.out_pid), 128'(1'b0));
    chk("rst.sop", 128'(bus.out_sop), 128'(1'b0));
    chk("rst.eop", 128'(bus.out_eop), 128'(1'b0));
    chk("rst.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick(); reset_n = 1'b1;
    bus.in_valid = 1'b1; bus.in_tmask = 4'b1111; bus.in_hdr = H1;
    @(negedge clk); chk("t1.in_ready_idle", 128'(bus.in_ready), 128'(1'b1));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t1.b0", 1'b0, 1'b1, 1'b0, 2'b11, H1);
    chk("t1.b0.rs1", 128'(bus.out_rs1), 128'(LO1));
    chk("t1.b0.in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    @(negedge clk); beat("t1.b1", 1'b1, 1'b0, 1'b1, 2'b11, H1);
    chk("t1.b1.rs1", 128'(bus.out_rs1), 128'(HI1));
    chk("t1.b1.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    @(negedge clk); chk("t1.idle", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_tmask = 4'b1100; bus.in_hdr = H2;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t2.b", 1'b1, 1'b1, 1'b1, 2'b11, H2);
    chk("t2.rs1", 128'(bus.out_rs1), 128'(HI1));
    chk("t2.rs2", 128'(bus.out_rs2), 128'(HI2));
    chk("t2.rs3", 128'(bus.out_rs3), 128'(HI3));
    tick();
    @(negedge clk); chk("t2.idle", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_tmask = 4'b0000; bus.in_hdr = H3;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t3.b", 1'b0, 1'b1, 1'b1, 2'b00, H3);
    tick();
    @(negedge clk); chk("t3.idle", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_tmask = 4'b1111; bus.in_hdr = H4;
    tick(); bus.in_hdr = H5;
    @(negedge clk); beat("t4.a0", 1'b0, 1'b1, 1'b0, 2'b11, H4);
    chk("t4.a0.in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    @(negedge clk); beat("t4.a1", 1'b1, 1'b0, 1'b1, 2'b11, H4);
    chk("t4.a1.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t4.b0", 1'b0, 1'b1, 1'b0, 2'b11, H5);
    tick();
    @(negedge clk); beat("t4.b1", 1'b1, 1'b0, 1'b1, 2'b11, H5);
    tick();
    @(negedge clk); chk("t4.idle", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_tmask = 4'b1011; bus.in_hdr = H6;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t5.b0", 1'b0, 1'b1, 1'b0, 2'b11, H6);
    tick(); bus.out_ready = 1'b0; bus.in_valid = 1'b1; bus.in_tmask = 4'b0000; bus.in_hdr = H7;
    @(negedge clk); beat("t5.stall1", 1'b1, 1'b0, 1'b1, 2'b10, H6);
    chk("t5.stall1.rs1", 128'(bus.out_rs1), 128'(HI1));
    chk("t5.stall1.in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick();
    @(negedge clk); beat("t5.stall2", 1'b1, 1'b0, 1'b1, 2'b10, H6);
    chk("t5.stall2.rs1", 128'(bus.out_rs1), 128'(HI1));
    chk("t5.stall2.in_ready", 128'(bus.in_ready), 128'(1'b0));
    tick(); bus.out_ready = 1'b1;
    @(negedge clk); beat("t5.go", 1'b1, 1'b0, 1'b1, 2'b10, H6);
    chk("t5.go.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t5.next", 1'b0, 1'b1, 1'b1, 2'b00, H7);
    tick();
    @(negedge clk); chk("t5.idle", 128'(bus.out_valid), 128'(1'b0));
    bus.in_valid = 1'b1; bus.in_tmask = 4'b1111; bus.in_hdr = H8;
    tick(); bus.in_valid = 1'b0;
    @(negedge clk); beat("t6.b0", 1'b0, 1'b1, 1'b0, 2'b11, H8);
    tick(); reset_n = 1'b0;
    #1;
    chk("t6.rst.valid", 128'(bus.out_valid), 128'(1'b0));
    chk("t6.rst.pid", 128'(bus.out_pid), 128'(1'b0));
    chk("t6.rst.eop", 128'(bus.out_eop), 128'(1'b0));
    chk("t6.rst.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick(); reset_n = 1'b1;
    @(negedge clk);
    chk("t6.post.valid", 128'(bus.out_valid), 128'(1'b0));
    chk("t6.post.in_ready", 128'(bus.in_ready), 128'(1'b1));
    tick();
    @(negedge clk); chk("t6.post2.valid", 128'(bus.out_valid), 128'(1'b0));
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
